// File: rtl/spi_burst_ctrl_pkg.sv
// Shared definitions for the SPI burst sequencer.
//  - default geometry of the TX/RX byte FIFOs and the burst length field
//  - minimum chip-select idle time after a burst
//  - FSM state encoding (3-bit)
package spi_burst_ctrl_pkg;

  localparam int DEF_DEPTH  = 8;  // TX and RX FIFO depth, power of 2
  localparam int DEF_AW     = 3;  // log2(DEF_DEPTH)
  localparam int DEF_LENW   = 4;  // burst_len width
  localparam int DEF_CS_GAP = 2;  // idle cycles with m_transmit=0 after a burst

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SEND   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// Show-ahead byte FIFO used for both the TX and RX queues of spi_burst_ctrl.
// Ports:
//  clk, rst     clock and asynchronous active-high reset
//  push, din    write din when there is room (or when a pop frees a slot this cycle)
//  pop          drop the head word; ignored while empty
//  dout         current head word (valid while !empty)
//  full, empty  occupancy flags
//  count        exact occupancy 0..DEPTH
module spi_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a full-FIFO push needs; callers that
  // must not use that slot (TX side) gate push with !full themselves.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array has no reset; only pointers and count define validity,
  // which keeps the array mappable to plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally modulo DEPTH because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of an SPI master. The host queues TX bytes, then
// starts a burst of burst_len bytes; the block holds m_transmit for the whole
// burst, presents bytes one at a time on m_d_valid/m_data with one idle cycle
// between bytes, and captures each returned byte into an RX FIFO.
// Ports:
//  CLK_M, reset                     clock, asynchronous active-high reset
//  wr_en, wr_data, tx_full, tx_count  host side of the TX FIFO
//  start, burst_len, start_err      burst request and rejection pulse
//  busy, burst_done                 status (busy in every state but IDLE)
//  rd_en, rd_data, rx_empty         host side of the RX FIFO (rd_data registered)
//  rx_overflow                      sticky: a returned byte was dropped
//  m_transmit, m_d_valid, m_data    to the SPI master
//  m_done, m_rx                     from the SPI master
module spi_burst_ctrl
  import spi_burst_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = DEF_AW,
  parameter int LENW   = DEF_LENW,
  parameter int CS_GAP = DEF_CS_GAP
) (
  input  logic            CLK_M,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  output logic            tx_full,
  output logic [AW:0]     tx_count,
  input  logic            start,
  input  logic [LENW-1:0] burst_len,
  output logic            start_err,
  output logic            busy,
  output logic            burst_done,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  output logic            rx_empty,
  output logic            rx_overflow,
  output logic            m_transmit,
  output logic            m_d_valid,
  output logic [7:0]      m_data,
  input  logic            m_done,
  input  logic [7:0]      m_rx
);

  localparam int GW = $clog2(CS_GAP + 1);
  localparam int CW = (AW + 1 > LENW) ? AW + 1 : LENW;

  state_e          state_q, state_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            start_err_q, start_err_d;
  logic            burst_done_q, burst_done_d;
  logic [7:0]      m_data_q;
  logic [7:0]      rd_data_q;
  logic            rx_overflow_q;

  logic            load_byte;
  logic            capture;
  logic            len_ok;
  logic            tx_push, tx_pop, tx_empty;
  logic [7:0]      tx_head;
  logic            rx_pop, rx_full;
  logic [7:0]      rx_head;
  logic [AW:0]     unused_rx_count;  // host only needs rx_empty

  assign tx_push = wr_en && !tx_full;
  assign tx_pop  = load_byte && !tx_empty;
  assign rx_pop  = rd_en && !rx_empty;

  spi_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk   (CLK_M),
    .rst   (reset),
    .push  (tx_push),
    .din   (wr_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  spi_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk   (CLK_M),
    .rst   (reset),
    .push  (capture),
    .din   (m_rx),
    .pop   (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (unused_rx_count)
  );

  // Start is accepted only when the whole burst is already queued.
  assign len_ok = (burst_len != '0) && (CW'(tx_count) >= CW'(burst_len));

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred; combinational logic uses '='.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    start_err_d  = 1'b0;
    burst_done_d = 1'b0;
    load_byte    = 1'b0;
    capture      = 1'b0;
    m_transmit   = 1'b0;
    m_d_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            rem_d   = burst_len;
            state_d = ST_ARM;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      ST_ARM: begin
        m_transmit = 1'b1;
        load_byte  = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        m_transmit = 1'b1;
        m_d_valid  = 1'b1;
        if (m_done) begin
          capture = 1'b1;
          rem_d   = rem_q - LENW'(1);
          if (rem_q > LENW'(1)) begin
            state_d = ST_GAP;
          end else begin
            state_d      = ST_FINISH;
            gap_d        = GW'(CS_GAP);
            burst_done_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        m_transmit = 1'b1;
        load_byte  = 1'b1;
        state_d    = ST_SEND;
      end
      ST_FINISH: begin
        // gap_q counts the remaining idle cycles including this one.
        if (gap_q <= GW'(1)) state_d = ST_IDLE;
        else                 gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK_M or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rem_q         <= '0;
      gap_q         <= '0;
      start_err_q   <= 1'b0;
      burst_done_q  <= 1'b0;
      m_data_q      <= '0;
      rd_data_q     <= '0;
      rx_overflow_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      gap_q        <= gap_d;
      start_err_q  <= start_err_d;
      burst_done_q <= burst_done_d;
      if (tx_pop) m_data_q  <= tx_head;
      if (rx_pop) rd_data_q <= rx_head;
      // A host pop in the same cycle makes room, so only a truly full RX drops.
      if (capture && rx_full && !rx_pop) rx_overflow_q <= 1'b1;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign start_err   = start_err_q;
  assign burst_done  = burst_done_q;
  assign m_data      = m_data_q;
  assign rd_data     = rd_data_q;
  assign rx_overflow = rx_overflow_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a behavioural SPI master:
// m_done pulses 10 cycles after each m_d_valid rise, returning ~m_data.
module tb_spi_burst_ctrl;

  logic       CLK_M = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_full;
  logic [3:0] tx_count;
  logic       start;
  logic [3:0] burst_len;
  logic       start_err;
  logic       busy;
  logic       burst_done;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic       rx_overflow;
  logic       m_transmit;
  logic       m_d_valid;
  logic [7:0] m_data;
  logic       m_done;
  logic [7:0] m_rx;

  // master model / manual override
  logic       model_en;
  logic       mdl_done;
  logic [7:0] mdl_rx;
  logic       man_done;
  logic [7:0] man_rx;
  int         mcnt;
  logic       mprev;

  // monitor state
  logic [7:0] sent_q[$];
  int         gap_q[$];
  int         gap_run;
  logic       in_burst;
  logic       prev_dv;
  int         bd_cnt;
  int         fin_cyc;
  int         serr_cnt;

  int total = 0;
  int bad   = 0;

  assign m_done = model_en ? mdl_done : man_done;
  assign m_rx   = model_en ? mdl_rx   : man_rx;

  always #5 CLK_M = ~CLK_M;

  spi_burst_ctrl dut (
    .CLK_M       (CLK_M),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .tx_full     (tx_full),
    .tx_count    (tx_count),
    .start       (start),
    .burst_len   (burst_len),
    .start_err   (start_err),
    .busy        (busy),
    .burst_done  (burst_done),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rx_empty    (rx_empty),
    .rx_overflow (rx_overflow),
    .m_transmit  (m_transmit),
    .m_d_valid   (m_d_valid),
    .m_data      (m_data),
    .m_done      (m_done),
    .m_rx        (m_rx)
  );

  // Behavioural master: reply 10 cycles after each m_d_valid rise.
  always @(negedge CLK_M) begin
    mdl_done = 1'b0;
    if (reset) begin
      mcnt  = 0;
      mprev = 1'b0;
    end else begin
      if (m_d_valid && !mprev) begin
        mcnt = 10;
      end else if (mcnt > 0) begin
        mcnt = mcnt - 1;
        if (mcnt == 0) begin
          mdl_done = 1'b1;
          mdl_rx   = ~m_data;
        end
      end
      mprev = m_d_valid;
    end
  end

  // Monitor: bytes presented, idle-cycle runs between bytes, pulse counts.
  always @(negedge CLK_M) begin
    if (reset) begin
      prev_dv  = 1'b0;
      gap_run  = 0;
      in_burst = 1'b0;
    end else begin
      if (m_d_valid && !prev_dv) begin
        sent_q.push_back(m_data);
        if (gap_run > 0) gap_q.push_back(gap_run);
        gap_run  = 0;
        in_burst = 1'b1;
      end else if (m_transmit && !m_d_valid && in_burst) begin
        gap_run = gap_run + 1;
      end
      if (!m_transmit) begin
        in_burst = 1'b0;
        gap_run  = 0;
      end
      if (burst_done)          bd_cnt   = bd_cnt + 1;
      if (busy && !m_transmit) fin_cyc  = fin_cyc + 1;
      if (start_err)           serr_cnt = serr_cnt + 1;
      prev_dv = m_d_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge CLK_M);
    wr_en   = 1'b0;
  endtask

  task automatic pop(output logic [7:0] b);
    rd_en = 1'b1;
    @(negedge CLK_M);
    rd_en = 1'b0;
    b     = rd_data;
  endtask

  task automatic do_start(input logic [3:0] len);
    start     = 1'b1;
    burst_len = len;
    @(negedge CLK_M);
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge CLK_M);
      n++;
    end while (busy && n < budget);
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_sent(input int k, input int budget);
    int n = 0;
    while (sent_q.size() < k && n < budget) begin
      @(negedge CLK_M);
      #1;
      n++;
    end
    check("sent_timeout", {31'd0, sent_q.size() >= k}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    int base_s, base_g, base_bd, base_fin, base_se, n;
    logic [7:0] exp_rx [8];

    bd_cnt = 0; fin_cyc = 0; serr_cnt = 0;
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; burst_len = '0;
    rd_en = 1'b0; model_en = 1'b1; man_done = 1'b0; man_rx = '0;
    mdl_done = 1'b0; mdl_rx = '0;
    repeat (2) @(negedge CLK_M);

    // reset state
    check("rst_m_transmit", {31'd0, m_transmit}, 32'd0);
    check("rst_m_d_valid", {31'd0, m_d_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_count", {28'd0, tx_count}, 32'd0);
    check("rst_tx_full", {31'd0, tx_full}, 32'd0);
    check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("rst_rx_overflow", {31'd0, rx_overflow}, 32'd0);
    check("rst_start_err", {31'd0, start_err}, 32'd0);
    check("rst_burst_done", {31'd0, burst_done}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    reset = 1'b0;
    @(negedge CLK_M);

    // 1: three-byte burst
    push(8'hA5); push(8'h3C); push(8'hFF);
    check("t1_tx_count", {28'd0, tx_count}, 32'd3);
    base_s = sent_q.size(); base_g = gap_q.size(); base_bd = bd_cnt; base_fin = fin_cyc;
    do_start(4'd3);
    check("t1_arm_busy", {31'd0, busy}, 32'd1);
    check("t1_arm_transmit", {31'd0, m_transmit}, 32'd1);
    check("t1_arm_dvalid", {31'd0, m_d_valid}, 32'd0);
    wait_idle(200);
    check("t1_nbytes", sent_q.size() - base_s, 32'd3);
    check("t1_byte0", {24'd0, sent_q[base_s]}, 32'hA5);
    check("t1_byte1", {24'd0, sent_q[base_s+1]}, 32'h3C);
    check("t1_byte2", {24'd0, sent_q[base_s+2]}, 32'hFF);
    check("t1_ngaps", gap_q.size() - base_g, 32'd2);
    check("t1_gap0", gap_q[base_g], 32'd1);
    check("t1_gap1", gap_q[base_g+1], 32'd1);
    check("t1_burst_done_cnt", bd_cnt - base_bd, 32'd1);
    check("t1_cs_gap_cycles", fin_cyc - base_fin, 32'd2);
    check("t1_tx_count_after", {28'd0, tx_count}, 32'd0);
    check("t1_rx_not_empty", {31'd0, rx_empty}, 32'd0);
    pop(b); check("t1_rx0", {24'd0, b}, 32'h5A);
    pop(b); check("t1_rx1", {24'd0, b}, 32'hC3);
    pop(b); check("t1_rx2", {24'd0, b}, 32'h00);
    check("t1_rx_empty", {31'd0, rx_empty}, 32'd1);

    // 2: not enough bytes queued
    push(8'h11); push(8'h22);
    do_start(4'd3);
    check("t2_start_err", {31'd0, start_err}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    @(negedge CLK_M);
    check("t2_start_err_clr", {31'd0, start_err}, 32'd0);
    check("t2_busy2", {31'd0, busy}, 32'd0);
    check("t2_tx_count", {28'd0, tx_count}, 32'd2);

    // 3: zero length rejected; start while busy ignored
    do_start(4'd0);
    check("t3_len0_err", {31'd0, start_err}, 32'd1);
    @(negedge CLK_M);
    push(8'h33);
    base_s = sent_q.size(); base_se = serr_cnt;
    do_start(4'd3);
    repeat (3) @(negedge CLK_M);
    do_start(4'd1);
    wait_idle(200);
    check("t3_nbytes", sent_q.size() - base_s, 32'd3);
    check("t3_byte0", {24'd0, sent_q[base_s]}, 32'h11);
    check("t3_byte2", {24'd0, sent_q[base_s+2]}, 32'h33);
    check("t3_no_start_err", serr_cnt - base_se, 32'd0);
    check("t3_tx_count", {28'd0, tx_count}, 32'd0);
    pop(b); check("t3_rx0", {24'd0, b}, 32'hEE);
    pop(b); check("t3_rx1", {24'd0, b}, 32'hDD);
    pop(b); check("t3_rx2", {24'd0, b}, 32'hCC);

    // 4: TX full, RX fills exactly, then overflows
    for (int i = 0; i < 9; i++) push(8'h80 + 8'(i));
    check("t4_tx_count", {28'd0, tx_count}, 32'd8);
    check("t4_tx_full", {31'd0, tx_full}, 32'd1);
    base_s = sent_q.size();
    do_start(4'd8);
    wait_idle(400);
    check("t4_nbytes", sent_q.size() - base_s, 32'd8);
    check("t4_first", {24'd0, sent_q[base_s]}, 32'h80);
    check("t4_last", {24'd0, sent_q[base_s+7]}, 32'h87);
    check("t4_no_overflow", {31'd0, rx_overflow}, 32'd0);
    push(8'h99);
    do_start(4'd1);
    wait_idle(100);
    check("t4_overflow", {31'd0, rx_overflow}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      pop(b);
      check($sformatf("t4_rx%0d", i), {24'd0, b}, 32'h7F - 32'(i));
    end
    check("t4_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("t4_overflow_sticky", {31'd0, rx_overflow}, 32'd1);
    pop(b);
    check("t4_pop_empty_holds", {24'd0, b}, 32'h78);

    // 5: reset during the second SEND
    push(8'h01); push(8'h02); push(8'h03);
    base_s = sent_q.size();
    do_start(4'd3);
    wait_sent(base_s + 2, 100);
    check("t5_in_send", {31'd0, m_d_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_transmit_drop", {31'd0, m_transmit}, 32'd0);
    check("t5_dvalid_drop", {31'd0, m_d_valid}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_tx_count", {28'd0, tx_count}, 32'd0);
    check("t5_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("t5_overflow_clr", {31'd0, rx_overflow}, 32'd0);
    repeat (2) @(negedge CLK_M);
    reset = 1'b0;
    @(negedge CLK_M);

    // 6: host pop coincides with capture into a full RX FIFO
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    do_start(4'd8);
    wait_idle(400);
    check("t6_full_no_ovf", {31'd0, rx_overflow}, 32'd0);
    push(8'h55);
    model_en = 1'b0;
    do_start(4'd1);
    n = 0;
    while (!m_d_valid && n < 20) begin
      @(negedge CLK_M);
      n++;
    end
    check("t6_dvalid_seen", {31'd0, m_d_valid}, 32'd1);
    man_rx   = 8'h12;
    man_done = 1'b1;
    rd_en    = 1'b1;
    @(negedge CLK_M);
    man_done = 1'b0;
    rd_en    = 1'b0;
    check("t6_rd_oldest", {24'd0, rd_data}, 32'hBF);
    check("t6_no_overflow", {31'd0, rx_overflow}, 32'd0);
    wait_idle(50);
    model_en = 1'b1;
    exp_rx = '{8'hBE, 8'hBD, 8'hBC, 8'hBB, 8'hBA, 8'hB9, 8'hB8, 8'h12};
    for (int i = 0; i < 8; i++) begin
      pop(b);
      check($sformatf("t6_rx%0d", i), {24'd0, b}, {24'd0, exp_rx[i]});
    end
    check("t6_rx_empty", {31'd0, rx_empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
